// File: rtl/cache_axi_bridge.sv
// Bridges the I-cache and D-cache SRAM-like ports onto one AXI master port.
// Only one single-beat transaction is in flight, and the D side wins ties.
module cache_axi_bridge (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_rdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [7:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,
   output logic [3:0]  wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic [3:0]  bid,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   localparam logic [3:0] INST_ID = 4'd0;
   localparam logic [3:0] DATA_ID = 4'd1;

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] wdata_q, wdata_d;
   logic        wr_q, wr_d;
   logic        src_q, src_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      size_d    = size_q;
      wdata_d   = wdata_q;
      wr_d      = wr_q;
      src_d     = src_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      case (state_q)
         IDLE: begin
            if (data_req) begin
               addr_d    = data_addr;
               size_d    = data_size;
               wdata_d   = data_wdata;
               wr_d      = data_wr;
               src_d     = 1'b1;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = data_wr ? WR_ADDR : RD_ADDR;
            end else if (inst_req) begin
               addr_d  = inst_addr;
               size_d  = inst_size;
               wdata_d = '0;
               wr_d    = 1'b0;
               src_d   = 1'b0;
               state_d = RD_ADDR;
            end
         end
         RD_ADDR: if (arready) state_d = RD_DATA;
         RD_DATA: if (rvalid) state_d = IDLE;
         WR_ADDR: begin
            // AW and W may complete in either order or together
            aw_done_d = aw_done_q | awready;
            w_done_d  = w_done_q | wready;
            if (aw_done_d && w_done_d) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = WR_RESP;
            end
         end
         WR_RESP: if (bvalid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         size_q    <= '0;
         wdata_q   <= '0;
         wr_q      <= 1'b0;
         src_q     <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         size_q    <= size_d;
         wdata_q   <= wdata_d;
         wr_q      <= wr_d;
         src_q     <= src_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   // Handshake outputs are masked while reset is asserted so an abandoned transfer stays silent
   assign data_addr_ok = rst && (state_q == IDLE) && data_req;
   assign inst_addr_ok = rst && (state_q == IDLE) && !data_req && inst_req;
   assign inst_data_ok = rst && (state_q == RD_DATA) && rvalid && !src_q;
   assign data_data_ok = rst && (((state_q == RD_DATA) && rvalid && src_q) ||
                                 ((state_q == WR_RESP) && bvalid));
   assign inst_rdata   = rdata;
   assign data_rdata   = rdata;

   assign arvalid = rst && (state_q == RD_ADDR);
   assign rready  = rst && (state_q == RD_DATA);
   assign awvalid = rst && (state_q == WR_ADDR) && !aw_done_q;
   assign wvalid  = rst && (state_q == WR_ADDR) && !w_done_q;
   assign bready  = rst && (state_q == WR_RESP);

   assign arid    = src_q ? DATA_ID : INST_ID;
   assign araddr  = addr_q;
   assign arsize  = {1'b0, size_q};
   assign arlen   = 8'd0;
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;

   assign awid    = DATA_ID;
   assign awaddr  = addr_q;
   assign awsize  = {1'b0, size_q};
   assign awlen   = 8'd0;
   assign awburst = 2'b01;
   assign awlock  = 2'b00;
   assign awcache = 4'd0;
   assign awprot  = 3'd0;

   assign wid   = DATA_ID;
   assign wdata = wdata_q;
   assign wlast = 1'b1;

   always_comb begin
      case (size_q)
         2'd0:    wstrb = 4'b0001 << addr_q[1:0];
         2'd1:    wstrb = 4'b0011 << addr_q[1:0];
         default: wstrb = 4'b1111;
      endcase
   end

   logic unused_ok;
   assign unused_ok = ^{inst_wr, rid, rresp, rlast, bid, bresp, wr_q};

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: inputs change on the falling edge,
// outputs are checked 1 ns later against hand-computed values.
module tb_cache_axi_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req, inst_wr;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr, inst_rdata;
   logic        inst_addr_ok, inst_data_ok;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        data_addr_ok, data_data_ok;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst, arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst, awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid, awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid, bready;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cache_axi_bridge dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Group of all valid/ready outputs: {arvalid, rready, awvalid, wvalid, bready}
   function automatic logic [31:0] hs();
      return {27'd0, arvalid, rready, awvalid, wvalid, bready};
   endfunction

   initial begin
      rst = 1'b0;
      inst_req = 0; inst_wr = 0; inst_size = 2'd0; inst_addr = '0;
      data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h0000_2000; data_wdata = '0;
      arready = 0; rid = 4'd0; rdata = '0; rresp = 2'd0; rlast = 1; rvalid = 0;
      awready = 0; wready = 0; bid = 4'd0; bresp = 2'd0; bvalid = 0;

      // Reset held three cycles with data_req asserted
      for (int i = 0; i < 3; i++) begin
         cyc(); #1;
         chk("rst_hs", hs(), 32'd0);
         chk("rst_daok", data_addr_ok, 1'b0);
         chk("rst_iaok", inst_addr_ok, 1'b0);
         chk("rst_ddok", data_data_ok, 1'b0);
      end

      // Release: D read accepted in the first cycle
      cyc(); rst = 1'b1; #1;
      chk("rel_daok", data_addr_ok, 1'b1);
      cyc(); data_req = 0; arready = 1; #1;
      chk("rel_arvalid", arvalid, 1'b1);
      chk("rel_araddr", araddr, 32'h0000_2000);
      cyc(); arready = 0; rvalid = 1; rdata = 32'h1111_2222; #1;
      chk("rel_ddok", data_data_ok, 1'b1);
      chk("rel_rdata", data_rdata, 32'h1111_2222);
      cyc(); rvalid = 0; #1;
      chk("rel_ddok_off", data_data_ok, 1'b0);

      // I-read of 0x1FC0_0000
      inst_req = 1; inst_addr = 32'h1FC0_0000; inst_size = 2'd2; #1;
      chk("ird_iaok", inst_addr_ok, 1'b1);
      chk("ird_daok", data_addr_ok, 1'b0);
      cyc(); inst_req = 0; arready = 1; #1;
      chk("ird_hs", hs(), 32'b10000);
      chk("ird_arid", arid, 4'd0);
      chk("ird_arsize", arsize, 3'b010);
      chk("ird_araddr", araddr, 32'h1FC0_0000);
      chk("ird_iaok_busy", inst_addr_ok, 1'b0);
      cyc(); arready = 0; rvalid = 1; rdata = 32'h2408_0001; #1;
      chk("ird_rready", rready, 1'b1);
      chk("ird_idok", inst_data_ok, 1'b1);
      chk("ird_rdata", inst_rdata, 32'h2408_0001);
      chk("ird_ddok", data_data_ok, 1'b0);
      cyc(); rvalid = 0; #1;
      chk("ird_idok_off", inst_data_ok, 1'b0);

      // D byte write of 0xAB to 0x8000_0013, awready late, wready immediate
      data_req = 1; data_wr = 1; data_size = 2'd0; data_addr = 32'h8000_0013;
      data_wdata = 32'hABAB_ABAB; #1;
      chk("bw_daok", data_addr_ok, 1'b1);
      cyc(); data_req = 0; data_wr = 0; wready = 1; #1;
      chk("bw_hs1", hs(), 32'b00110);
      chk("bw_wstrb", wstrb, 4'b1000);
      chk("bw_awsize", awsize, 3'd0);
      chk("bw_awaddr", awaddr, 32'h8000_0013);
      chk("bw_wdata", wdata, 32'hABAB_ABAB);
      chk("bw_wid", wid, 4'd1);
      chk("bw_awid", awid, 4'd1);
      chk("bw_wlast", wlast, 1'b1);
      cyc(); wready = 0; #1;
      chk("bw_hs2", hs(), 32'b00100);
      cyc(); awready = 1; #1;
      chk("bw_hs3", hs(), 32'b00100);
      chk("bw_awaddr3", awaddr, 32'h8000_0013);
      cyc(); awready = 0; bvalid = 1; #1;
      chk("bw_hs4", hs(), 32'b00001);
      chk("bw_ddok", data_data_ok, 1'b1);
      cyc(); bvalid = 0; #1;
      chk("bw_ddok_off", data_data_ok, 1'b0);
      chk("bw_idle_hs", hs(), 32'd0);

      // Simultaneous requests: D read first, then I read
      inst_req = 1; inst_addr = 32'h1FC0_0004; inst_size = 2'd2;
      data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h0000_1000; #1;
      chk("sim_daok", data_addr_ok, 1'b1);
      chk("sim_iaok", inst_addr_ok, 1'b0);
      cyc(); data_req = 0; arready = 1; #1;
      chk("sim_arid_d", arid, 4'd1);
      chk("sim_araddr_d", araddr, 32'h0000_1000);
      chk("sim_iaok_busy", inst_addr_ok, 1'b0);
      cyc(); arready = 0; rvalid = 1; rdata = 32'hD0D0_D0D0; #1;
      chk("sim_ddok", data_data_ok, 1'b1);
      chk("sim_idok0", inst_data_ok, 1'b0);
      cyc(); rvalid = 0; #1;
      chk("sim_iaok_next", inst_addr_ok, 1'b1);
      cyc(); inst_req = 0; arready = 1; #1;
      chk("sim_arid_i", arid, 4'd0);
      chk("sim_araddr_i", araddr, 32'h1FC0_0004);
      cyc(); arready = 0; rvalid = 1; rdata = 32'h0000_1234; #1;
      chk("sim_idok", inst_data_ok, 1'b1);
      chk("sim_ddok0", data_data_ok, 1'b0);
      cyc(); rvalid = 0; #1;

      // Write-back followed by read miss, read request held while busy
      data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h8000_1000;
      data_wdata = 32'hCAFE_F00D; #1;
      chk("wb_daok", data_addr_ok, 1'b1);
      cyc(); data_wr = 0; data_addr = 32'h8000_2000; awready = 1; wready = 1; #1;
      chk("wb_hs1", hs(), 32'b00110);
      chk("wb_wstrb", wstrb, 4'b1111);
      chk("wb_daok_busy", data_addr_ok, 1'b0);
      cyc(); awready = 0; wready = 0; #1;
      chk("wb_hs2", hs(), 32'b00001);
      chk("wb_ddok_wait", data_data_ok, 1'b0);
      cyc(); bvalid = 1; #1;
      chk("wb_ddok", data_data_ok, 1'b1);
      chk("wb_noar", arvalid, 1'b0);
      chk("wb_daok_resp", data_addr_ok, 1'b0);
      cyc(); bvalid = 0; #1;
      chk("wb_ddok_off", data_data_ok, 1'b0);
      chk("rm_daok", data_addr_ok, 1'b1);
      cyc(); data_req = 0; arready = 1; #1;
      chk("rm_arvalid", arvalid, 1'b1);
      chk("rm_araddr", araddr, 32'h8000_2000);
      chk("rm_arid", arid, 4'd1);
      cyc(); arready = 0; rvalid = 1; rdata = 32'h5A5A_0F0F; #1;
      chk("rm_ddok", data_data_ok, 1'b1);
      chk("rm_rdata", data_rdata, 32'h5A5A_0F0F);
      cyc(); rvalid = 0; #1;
      chk("rm_ddok_off", data_data_ok, 1'b0);

      // Reset while waiting in RD_DATA abandons the read
      inst_req = 1; inst_addr = 32'h0000_0100; #1;
      chk("ab_iaok", inst_addr_ok, 1'b1);
      cyc(); inst_req = 0; arready = 1; #1;
      chk("ab_arvalid", arvalid, 1'b1);
      cyc(); arready = 0; #1;
      chk("ab_rready", rready, 1'b1);
      cyc(); rst = 1'b0; #1;
      chk("ab_rst_idok", inst_data_ok, 1'b0);
      cyc(); rst = 1'b1; rvalid = 1; rdata = 32'hDEAD_BEEF; #1;
      chk("ab_hs", hs(), 32'd0);
      chk("ab_idok", inst_data_ok, 1'b0);
      chk("ab_ddok", data_data_ok, 1'b0);
      cyc(); rvalid = 0; #1;
      chk("ab_idok2", inst_data_ok, 1'b0);
      inst_req = 1; #1;
      chk("ab_iaok_again", inst_addr_ok, 1'b1);
      cyc(); inst_req = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cache_axi_bridge.md
# cache_axi_bridge

Converts the SRAM-like request interfaces of the instruction cache and the write-back data cache into a single AXI master port. It sits directly downstream of both caches and drives the external AXI interconnect. It keeps one transaction outstanding at a time, with single-beat transfers and fixed data-over-instruction priority.

## Interface
- INST_ID, 4'd0, ARID used for instruction-side reads
- DATA_ID, 4'd1, ARID/AWID/WID used for data-side transfers
- clk  input  1  single clock; all logic on posedge
- rst  input  1  synchronous, active-low reset
- inst_req / inst_wr  input  1/1  I-cache request; inst_wr is ignored (reads only)
- inst_size / inst_addr  input  2/32  I-side size and byte address
- inst_rdata / inst_addr_ok / inst_data_ok  output  32/1/1  I-side return path
- data_req / data_wr  input  1/1  D-cache request and write flag
- data_size / data_addr / data_wdata  input  2/32/32  D-side size, address, write data
- data_rdata / data_addr_ok / data_data_ok  output  32/1/1  D-side return path
- arid/araddr/arsize/arvalid  output  4/32/3/1  AR channel
- arlen/arburst/arlock/arcache/arprot  output  8/2/2/4/3  AR constants
- arready  input  1  AR handshake
- rid/rdata/rresp/rlast/rvalid  input  4/32/2/1/1  R channel
- rready  output  1  R handshake
- awid/awaddr/awsize/awvalid  output  4/32/3/1  AW channel
- awlen/awburst/awlock/awcache/awprot  output  8/2/2/4/3  AW constants
- awready  input  1  AW handshake
- wid/wdata/wstrb/wlast/wvalid  output  4/32/4/1/1  W channel
- wready  input  1  W handshake
- bid/bresp/bvalid  input  4/2/1  B channel
- bready  output  1  B handshake

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.
- Request acceptance happens only in IDLE.
  - If data_req=1, the D side is granted; otherwise, if inst_req=1, the I side is granted.
  - Granted port gets addr_ok=1 combinationally in that cycle; the other port's addr_ok=0.
  - On acceptance, latch addr, size, wdata, wr and the source (src=1 for data).
  - Next state is WR_ADDR if the accepted request is a data write, else RD_ADDR.
- RD_ADDR: arvalid=1 with araddr=latched addr, arsize={1'b0,size}, arid=src?DATA_ID:INST_ID. On arready, go to RD_DATA.
- RD_DATA: rready=1. On rvalid:
  - Pulse data_ok for src for one cycle; that port's rdata = rdata (combinational pass-through).
  - Go to IDLE. rid and rresp are ignored.
- WR_ADDR: awvalid and wvalid are both raised on entry.
  - awvalid drops after an awready handshake; wvalid drops after a wready handshake. Each completion is tracked by its own done flag.
  - When both flags are done (including the same cycle), go to WR_RESP.
  - wdata = latched wdata; wid=DATA_ID; wlast=1.
- WR_RESP: bready=1. On bvalid, pulse data_data_ok and go to IDLE. bresp is ignored.
- wstrb by size, shifted by addr[1:0]:
  - size 0: 4'b0001<<addr[1:0]
  - size 1: 4'b0011<<addr[1:0]
  - size 2: 4'b1111
- AXI constants: len=0, burst=2'b01, lock=0, cache=0, prot=0.
- Address is passed through unmodified; write-back lines from the D-cache arrive as size 2, word-aligned.
- inst_rdata/data_rdata equal rdata at all times; they are valid only while the matching data_ok is high.

## Timing
- Reset (rst=0 at posedge): state=IDLE, done flags cleared, latched registers zeroed.
  - All valid/ready outputs (arvalid, awvalid, wvalid, rready, bready) are 0.
  - All addr_ok/data_ok outputs are 0.
  - Reset mid-transaction abandons it with no data_ok.
- Read with zero-wait slave: accept at cycle T, arvalid at T+1, rvalid/data_ok at T+2, next acceptance possible at T+3.
- Write with zero-wait slave: accept at T, AW+W at T+1, B/data_ok at T+2, next acceptance possible at T+3.
- addr_ok is never asserted outside IDLE. A requester holding req while the bridge is busy stalls with no side effects.
- Exactly one data_ok pulse is produced per accepted request, in order.
- AXI outputs are stable while valid=1 and ready=0.
- Simultaneous inst_req and data_req in IDLE: data wins; inst is accepted at its next IDLE if still held.

## Test plan
- Reset: hold rst=0 for 3 cycles with data_req=1 -> all valids, addr_ok and data_ok stay 0. Release -> data_addr_ok=1 in the first cycle.
- I-read of 0x1FC0_0000, arready=1, rvalid one cycle later with rdata=0x2408_0001:
  - arid=0, arsize=3'b010.
  - inst_data_ok pulses with inst_rdata=0x2408_0001, 2 cycles after inst_addr_ok.
- D byte write of 0xAB to 0x8000_0013: wstrb=4'b1000, awsize=0. awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 3 cycles, data_data_ok on bvalid.
- Simultaneous inst_req and data_req (D read 0x0000_1000):
  - D is served first (arid=1); I is accepted the cycle after D returns to IDLE.
  - data_ok pulses occur in D, I order.
- Back-to-back D write-back (size 2) followed by D read miss: AW/W then AR. No AR is issued before bvalid, and each of the two data_data_ok is a single-cycle pulse.
- Assert rst=0 in RD_DATA before rvalid: the bridge returns to IDLE, no data_ok is produced, and a later rvalid is ignored with rready=0.
